// File: rtl/mem_prefix_sum_ctrl.sv
// rtl/mem_prefix_sum_ctrl.sv - prefix-sum sequencer driving a 32-bit word memory's read and write ports
//
// Purpose:
//   On an accepted start, reads COUNT words beginning at SRC_BASE and keeps a
//   running 32-bit sum. After each read it writes the running sum to
//   DST_BASE + i. When the run ends it pulses done, which the memory uses as
//   its dump trigger. The memory read path is combinational, so the word
//   arrives in the same cycle that mem_addr and mem_read are presented.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset; aborts a run, no done pulse
//   start           one-cycle begin request, honoured only in IDLE
//   mem_addr        read address (held between reads)
//   mem_read        read enable, high only in READ
//   mem_rdata       read data, valid in the same cycle as mem_read
//   mem_we          write enable, high only in WRITE
//   mem_write_addr  write address (held between writes)
//   mem_wdata       write data = running sum (held between writes)
//   done            one-cycle completion pulse
//   busy            high in every non-IDLE state
//   sum             final total, held until the next accepted start
//   ovf             sticky accumulator carry-out, cleared on accepted start

module mem_prefix_sum_ctrl #(
   parameter int SIZE     = 128,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 64,
   parameter int COUNT    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  mem_addr,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
   output logic [7:0]  mem_write_addr,
   output logic [31:0] mem_wdata,
   output logic        done,
   output logic        busy,
   output logic [31:0] sum,
   output logic        ovf
);

   // A region that would spill past the end of memory is never walked; such
   // a configuration degenerates to an empty run so no address reaches SIZE.
   localparam bit PARAMS_OK = (SRC_BASE + COUNT <= SIZE) && (DST_BASE + COUNT <= SIZE);
   localparam bit RUN_EMPTY = (COUNT == 0) || !PARAMS_OK;

   localparam logic [7:0] SRC_ADDR = 8'(SRC_BASE);
   localparam logic [7:0] DST_ADDR = 8'(DST_BASE);
   localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [7:0]  idx;
   logic [31:0] acc;
   logic [32:0] acc_sum;
   logic        accept;
   logic        is_last;

   // 33-bit add so the carry-out is visible for the sticky overflow flag.
   assign acc_sum = {1'b0, acc} + {1'b0, mem_rdata};
   assign is_last = (idx == LAST_IDX);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and state-decoded strobes
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      mem_read   = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
      busy       = 1'b1;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept     = 1'b1;
               state_next = RUN_EMPTY ? S_FINISH : S_READ;
            end
         end

         S_READ: begin
            mem_read   = 1'b1;
            state_next = S_WRITE;
         end

         S_WRITE: begin
            mem_we     = 1'b1;
            state_next = is_last ? S_FINISH : S_READ;
         end

         S_FINISH: begin
            // start is not looked at here, so a request on the done cycle
            // is dropped rather than chaining into a new run.
            done       = 1'b1;
            state_next = S_IDLE;
         end

         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: index, accumulator, address/data registers, result flags
   // ------------------------------------------------------------------
   // Addresses and write data are registered one transition ahead of the
   // state that uses them, so they are already stable when mem_read or
   // mem_we rises and simply hold while the strobes are low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx            <= 8'd0;
         acc            <= 32'd0;
         mem_addr       <= 8'd0;
         mem_write_addr <= 8'd0;
         mem_wdata      <= 32'd0;
         sum            <= 32'd0;
         ovf            <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  idx <= 8'd0;
                  acc <= 32'd0;
                  sum <= 32'd0;
                  ovf <= 1'b0;
                  if (!RUN_EMPTY) begin
                     mem_addr <= SRC_ADDR;
                  end
               end
            end

            S_READ: begin
               acc            <= acc_sum[31:0];
               mem_write_addr <= DST_ADDR + idx;
               mem_wdata      <= acc_sum[31:0];
               if (acc_sum[32]) begin
                  ovf <= 1'b1;
               end
            end

            S_WRITE: begin
               if (is_last) begin
                  // acc already holds the final total; publish it for the
                  // done cycle.
                  sum <= acc;
               end else begin
                  idx      <= idx + 8'd1;
                  mem_addr <= SRC_ADDR + idx + 8'd1;
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_prefix_sum_ctrl.sv
// tb/tb_mem_prefix_sum_ctrl.sv - randomized self-checking bench for mem_prefix_sum_ctrl

module tb_mem_prefix_sum_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Three instances: 0 = COUNT 4 into a separate region, 1 = COUNT 0,
   // 2 = in-place COUNT 3 with SRC_BASE == DST_BASE == 0.
   logic       go  = 1'b0;
   logic [1:0] sel = 2'd0;

   logic [2:0]        start_v;
   logic [2:0]        rd;
   logic [2:0]        we;
   logic [2:0]        done;
   logic [2:0]        busy;
   logic [2:0]        ovf;
   logic [2:0][7:0]   addr;
   logic [2:0][7:0]   waddr;
   logic [2:0][31:0]  rdata;
   logic [2:0][31:0]  wdata;
   logic [2:0][31:0]  sum;

   logic [31:0] mem [3][128];

   logic        ld_en   = 1'b0;
   logic [1:0]  ld_sel  = 2'd0;
   logic [7:0]  ld_addr = 8'd0;
   logic [31:0] ld_data = 32'd0;

   assign start_v = go ? 3'(3'b001 << sel) : 3'b000;

   always_comb begin
      for (int i = 0; i < 3; i++) rdata[i] = mem[i][addr[i][6:0]];
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) if (we[i]) mem[i][waddr[i][6:0]] <= wdata[i];
      if (ld_en) mem[ld_sel][ld_addr[6:0]] <= ld_data;
   end

   // Activity monitors
   int cyc = 0;
   int wr_cnt[3]   = '{0, 0, 0};
   int rd_cnt[3]   = '{0, 0, 0};
   int done_cnt[3] = '{0, 0, 0};
   int clash[3]    = '{0, 0, 0};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (we[i])          wr_cnt[i]   <= wr_cnt[i] + 1;
         if (rd[i])          rd_cnt[i]   <= rd_cnt[i] + 1;
         if (done[i])        done_cnt[i] <= done_cnt[i] + 1;
         if (rd[i] && we[i]) clash[i]    <= clash[i] + 1;
      end
   end

   mem_prefix_sum_ctrl #(.SIZE(128), .SRC_BASE(0), .DST_BASE(64), .COUNT(4)) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]),
      .mem_addr(addr[0]), .mem_read(rd[0]), .mem_rdata(rdata[0]),
      .mem_we(we[0]), .mem_write_addr(waddr[0]), .mem_wdata(wdata[0]),
      .done(done[0]), .busy(busy[0]), .sum(sum[0]), .ovf(ovf[0]));

   mem_prefix_sum_ctrl #(.SIZE(128), .SRC_BASE(0), .DST_BASE(64), .COUNT(0)) u_b (
      .clk(clk), .rst(rst), .start(start_v[1]),
      .mem_addr(addr[1]), .mem_read(rd[1]), .mem_rdata(rdata[1]),
      .mem_we(we[1]), .mem_write_addr(waddr[1]), .mem_wdata(wdata[1]),
      .done(done[1]), .busy(busy[1]), .sum(sum[1]), .ovf(ovf[1]));

   mem_prefix_sum_ctrl #(.SIZE(128), .SRC_BASE(0), .DST_BASE(0), .COUNT(3)) u_c (
      .clk(clk), .rst(rst), .start(start_v[2]),
      .mem_addr(addr[2]), .mem_read(rd[2]), .mem_rdata(rdata[2]),
      .mem_we(we[2]), .mem_write_addr(waddr[2]), .mem_wdata(wdata[2]),
      .done(done[2]), .busy(busy[2]), .sum(sum[2]), .ovf(ovf[2]));

   function automatic int cnt_of(input logic [1:0] s);
      return (s == 2'd0) ? 4 : (s == 2'd1) ? 0 : 3;
   endfunction

   function automatic int src_of(input logic [1:0] s);
      return 0;
   endfunction

   function automatic int dst_of(input logic [1:0] s);
      return (s == 2'd2) ? 0 : 64;
   endfunction

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [1:0] s, input int a, input logic [31:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_sel  = s;
      ld_addr = 8'(a);
      ld_data = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   function automatic logic [127:0] outs_of(input logic [1:0] s);
      return {addr[s], rd[s], we[s], waddr[s], wdata[s], done[s], busy[s], sum[s], ovf[s]};
   endfunction

   // One complete run on instance s. Expected results come from the source
   // words as they stand before the run: destination k gets the sum of
   // source words 0..k modulo 2^32, and ovf is set exactly when the true
   // total reaches 2^32.
   task automatic run(input logic [1:0] s, input bit ghost, input string tag);
      int          c;
      int          sb;
      int          db;
      logic [63:0] tot;
      logic [31:0] exp_dst[$];
      int          w0, r0, d0, cl0, st, k;
      bit          fin;

      c   = cnt_of(s);
      sb  = src_of(s);
      db  = dst_of(s);
      tot = 64'd0;
      for (int i = 0; i < c; i++) begin
         tot = tot + 64'(mem[s][sb + i]);
         exp_dst.push_back(tot[31:0]);
      end

      w0 = wr_cnt[s]; r0 = rd_cnt[s]; d0 = done_cnt[s]; cl0 = clash[s];

      @(negedge clk);
      sel = s;
      go  = 1'b1;
      st  = cyc;
      fin = 1'b0;
      for (int n = 0; n < 300 && !fin; n++) begin
         @(negedge clk);
         k  = cyc - st;
         go = ghost && (k == 3);
         if (k == 1) begin
            check({tag, "_busy_c1"}, 64'(busy[s]), 64'd1);
            check({tag, "_ovf_clr"}, 64'(ovf[s]), 64'd0);
         end
         if (done[s]) begin
            check({tag, "_done_cyc"}, 64'(k), 64'(2 * c + 1));
            check({tag, "_sum"}, 64'(sum[s]), 64'(tot[31:0]));
            check({tag, "_ovf"}, 64'(ovf[s]), 64'(tot[63:32] != 32'd0));
            check({tag, "_busy_done"}, 64'(busy[s]), 64'd1);
            go  = ghost;
            fin = 1'b1;
         end
      end
      if (!fin) check({tag, "_timeout"}, 64'd0, 64'd1);

      @(negedge clk);
      go = 1'b0;
      check({tag, "_done_1cyc"}, 64'(done[s]), 64'd0);
      check({tag, "_busy_after"}, 64'(busy[s]), 64'd0);
      repeat (4) @(negedge clk);
      check({tag, "_writes"}, 64'(wr_cnt[s] - w0), 64'(c));
      check({tag, "_reads"}, 64'(rd_cnt[s] - r0), 64'(c));
      check({tag, "_dones"}, 64'(done_cnt[s] - d0), 64'd1);
      check({tag, "_rd_we_clash"}, 64'(clash[s] - cl0), 64'd0);
      check({tag, "_sum_held"}, 64'(sum[s]), 64'(tot[31:0]));
      for (int i = 0; i < c; i++)
         check($sformatf("%s_dst%0d", tag, i), 64'(mem[s][db + i]), 64'(exp_dst[i]));
   endtask

   initial begin
      int          d0, st, k;
      logic [31:0] w;

      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++)
         check($sformatf("reset_outs%0d", s), 64'(outs_of(2'(s)) != 128'd0), 64'd0);
      rst = 1'b0;

      // Basic run 1,2,3,4 -> 1,3,6,10
      for (int i = 0; i < 4; i++) load(2'd0, i, 32'(i + 1));
      for (int i = 0; i < 4; i++) load(2'd0, 64 + i, 32'hDEAD_0000);
      run(2'd0, 1'b0, "basic");
      check("basic_dst3_const", 64'(mem[0][67]), 64'd10);

      // Carry-out: ovf set, sum wraps; a rerun with small words clears it
      load(2'd0, 0, 32'hFFFF_FFFF);
      load(2'd0, 1, 32'h0000_0002);
      load(2'd0, 2, 32'd0);
      load(2'd0, 3, 32'd0);
      run(2'd0, 1'b0, "ovf");
      check("ovf_sum_const", 64'(sum[0]), 64'd1);
      check("ovf_flag_const", 64'(ovf[0]), 64'd1);
      for (int i = 0; i < 4; i++) load(2'd0, i, 32'd1);
      run(2'd0, 1'b0, "ovf_rerun");

      // COUNT = 0
      run(2'd1, 1'b0, "zero");

      // Starts during the run and on the done cycle are ignored
      for (int i = 0; i < 4; i++) load(2'd0, i, 32'(7 * i + 3));
      run(2'd0, 1'b1, "ghost");

      // Asynchronous reset during the WRITE of element 2
      for (int i = 0; i < 4; i++) load(2'd0, i, 32'(i + 1));
      for (int i = 0; i < 4; i++) load(2'd0, 64 + i, 32'hBEEF_0000);
      d0 = done_cnt[0];
      @(negedge clk);
      sel = 2'd0;
      go  = 1'b1;
      st  = cyc;
      k   = 0;
      for (int n = 0; n < 20 && k < 6; n++) begin
         @(negedge clk);
         go = 1'b0;
         k  = cyc - st;
      end
      check("rst_we_at_c6", 64'(we[0]), 64'd1);
      check("rst_waddr_at_c6", 64'(waddr[0]), 64'd66);
      rst = 1'b1;
      #1;
      check("rst_outs_zero", 64'(outs_of(2'd0)), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_no_done", 64'(done_cnt[0] - d0), 64'd0);
      check("rst_no_write2", 64'(mem[0][66]), 64'hBEEF_0000);
      check("rst_write1_kept", 64'(mem[0][65]), 64'd3);
      run(2'd0, 1'b0, "after_rst");

      // In place: 5,5,5 -> 5,10,15
      for (int i = 0; i < 3; i++) load(2'd2, i, 32'd5);
      run(2'd2, 1'b0, "inplace");
      check("inplace_w2_const", 64'(mem[2][2]), 64'd15);

      // Randomized runs on the two non-empty instances
      for (int it = 0; it < 10; it++) begin
         logic [1:0] s;
         s = (it % 2 == 0) ? 2'd0 : 2'd2;
         for (int i = 0; i < cnt_of(s); i++) begin
            w = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
            load(s, src_of(s) + i, w);
         end
         if (s == 2'd0)
            for (int i = 0; i < 4; i++) load(s, 64 + i, 32'($urandom));
         run(s, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_prefix_sum_ctrl.md
Name: mem_prefix_sum_ctrl

Overview:
- Sequencing controller that sits directly in front of the 32-bit word memory; it drives that memory's read and write ports.
- On start, it reads COUNT words from a source region and computes a running sum. It writes each running sum into a destination region.
- It then pulses done, which the memory uses as its dump trigger.
- The memory read path is combinational, so read data is valid in the same cycle the address is presented.

Parameters:
- SIZE, 128, memory depth in words; all generated addresses stay below SIZE.
- SRC_BASE, 0, first source word address.
- DST_BASE, 64, first destination word address.
- COUNT, 64, number of words processed; 0 is legal. Requires SRC_BASE+COUNT<=SIZE and DST_BASE+COUNT<=SIZE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin; sampled only in IDLE.
- mem_addr  output  8  memory read address.
- mem_read  output  1  memory read enable.
- mem_rdata  input  32  memory read data, valid in the same cycle as mem_read.
- mem_we  output  1  memory write enable.
- mem_write_addr  output  8  memory write address.
- mem_wdata  output  32  memory write data.
- done  output  1  one-cycle completion pulse; connects to the memory done input.
- busy  output  1  high from the cycle after start is accepted until the cycle after done.
- sum  output  32  final total, held until the next start.
- ovf  output  1  sticky carry-out flag of the accumulator; cleared on start.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE; element index i=0, accumulator acc=0.
  - All outputs are 0: mem_addr, mem_read, mem_we, mem_write_addr, mem_wdata, done, busy, sum, ovf.
  - Memory writes already committed are not undone.
  - Reset mid-run aborts the run and produces no done pulse.
- States:
  - IDLE: start=1 clears i, acc, sum and ovf. Go to FINISH if COUNT==0, otherwise to READ.
  - READ: mem_read=1, mem_addr=SRC_BASE+i. Register acc_next = acc + mem_rdata, computed modulo 2^32. Set ovf if the 33-bit carry is 1. Go to WRITE.
  - WRITE: mem_we=1, mem_write_addr=DST_BASE+i, mem_wdata=acc (the value updated in READ). If i==COUNT-1, go to FINISH; else increment i and go to READ.
  - FINISH: done=1 for exactly one cycle and sum=acc. Go to IDLE.
- Outputs are registered or decoded from state; mem_read and mem_we are never high in the same cycle.
- When not in READ or WRITE, outputs are quiet: mem_read=0, mem_we=0, and addresses and data are held at their last value.
- Latency:
  - start sampled at edge 0; first READ in cycle 1; element k is written in cycle 2k+2.
  - done is high in cycle 2*COUNT+1. With COUNT=0, done is high in cycle 1.
- start is ignored while busy. start coinciding with the done cycle is also ignored.
- Index width is 8 bits. Wrap-around of i cannot occur given the parameter constraints.
- Overlapping source and destination regions are allowed. Each source word is read before any write to a higher index, so overlap with DST_BASE<=SRC_BASE behaves in place. Other overlaps read already-overwritten data, by definition.
- ovf is sticky until the next accepted start or reset.

Test Plan:
- Basic run, COUNT=4, source words 1,2,3,4 -> destination words 1,3,6,10; sum=10; ovf=0; done high in cycle 9 only.
- Overflow, COUNT=2, source words FFFFFFFF and 00000002 -> destination words FFFFFFFF and 00000001; sum=00000001; ovf=1. A second start clears ovf before the rerun.
- COUNT=0 -> done pulses in the cycle after start; no mem_read or mem_we ever asserted; sum=0.
- start pulsed again in cycle 3 of a COUNT=4 run, and again on the done cycle -> both ignored; exactly 4 writes and one done pulse.
- rst asserted asynchronously mid-WRITE of element 2 -> all outputs go to 0 immediately; no done pulse. A new start produces a full correct run.
- In-place run, SRC_BASE=DST_BASE=0, COUNT=3, words 5,5,5 -> memory words 0..2 become 5,10,15.
